// File: rtl/div_sign_ctrl.sv
// Sign-handling front/back end around an unsigned pipelined divider: RISC-V
// DIV/DIVU/REM/REMU with operand magnitude conversion, metadata pipe and fix-up.
module div_sign_ctrl #(
  parameter int DIV_LAT = 8,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [31:0]      i_rs1,
  input  logic [31:0]      i_rs2,
  input  logic [TAG_W-1:0] i_tag,
  output logic [31:0]      o_div_dividend,
  output logic [31:0]      o_div_divisor,
  input  logic [31:0]      i_div_quotient,
  input  logic [31:0]      i_div_remainder,
  output logic             o_valid,
  output logic [31:0]      o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic [3:0]       o_count
);

  localparam int DATA_W = 32;

  typedef struct packed {
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic [TAG_W-1:0] tag;
  } meta_t;

  // Magnitude of a signed operand; 0x80000000 maps onto itself as unsigned.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x,
                                            input logic take);
    return (take && (x < 0)) ? -x : x;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic signed [DATA_W-1:0] x,
                                                 input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [DATA_W-1:0] fixup(input meta_t m,
                                              input logic [DATA_W-1:0] q,
                                              input logic [DATA_W-1:0] r);
    if (m.is_rem) return cond_neg(r, m.neg_r);
    if (m.dz)     return '1;
    return cond_neg(q, m.neg_q);
  endfunction

  // Issue: operand magnitudes go straight to the divider
  logic  is_signed;
  logic  rs2_zero;
  meta_t meta_in;

  assign is_signed      = ~i_op[0];
  assign rs2_zero       = (i_rs2 == '0);
  assign o_div_dividend = mag(i_rs1, is_signed);
  assign o_div_divisor  = mag(i_rs2, is_signed);

  assign meta_in = '{
    is_rem: i_op[1],
    neg_q:  is_signed & (i_rs1[31] ^ i_rs2[31]) & ~rs2_zero,
    neg_r:  is_signed & i_rs1[31],
    dz:     rs2_zero,
    tag:    i_tag
  };

  // Metadata pipe p0..p(DIV_LAT-1), aligned with the divider stages
  logic [DIV_LAT-1:0] vld_p;
  meta_t              meta_p [DIV_LAT];
  logic               leave;

  assign leave = vld_p[DIV_LAT-1];

  always_ff @(posedge clk) begin
    if (rst)
      vld_p <= '0;
    else if (i_flush)
      vld_p <= {{(DIV_LAT-1){1'b0}}, i_valid};
    else
      vld_p <= {vld_p[DIV_LAT-2:0], i_valid};
  end

  always_ff @(posedge clk) begin
    meta_p[0] <= meta_in;
    for (int k = 1; k < DIV_LAT; k++)
      meta_p[k] <= meta_p[k-1];
  end

  // Occupancy: a flush leaves only the op issued alongside it
  logic [3:0] count_nxt;

  always_comb begin
    count_nxt = o_count;
    if (i_flush)
      count_nxt = {3'b000, i_valid};
    else begin
      case ({i_valid, leave})
        2'b10:   count_nxt = o_count + 4'd1;
        2'b01:   count_nxt = o_count - 4'd1;
        default: count_nxt = o_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      o_count <= '0;
    else
      o_count <= count_nxt;
  end

  // Completion: sign fix-up and special cases, result holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
    end else begin
      o_valid <= leave & ~i_flush;
      if (leave && !i_flush) begin
        o_result <= fixup(meta_p[DIV_LAT-1], i_div_quotient, i_div_remainder);
        o_tag    <= meta_p[DIV_LAT-1].tag;
      end
    end
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Scoreboard bench for div_sign_ctrl with a behavioural 8-stage unsigned divider.
module tb_div_sign_ctrl;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = '0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_tag = '0;
  logic [31:0] o_div_dividend, o_div_divisor;
  logic [31:0] i_div_quotient, i_div_remainder;
  logic        o_valid;
  logic [31:0] o_result;
  logic [4:0]  o_tag;
  logic [3:0]  o_count;

  div_sign_ctrl #(.DIV_LAT(8), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
    .o_valid(o_valid), .o_result(o_result), .o_tag(o_tag), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned divider: 8 register stages, x/0 gives all-ones quotient and dividend remainder
  logic [31:0] dq [8];
  logic [31:0] dr [8];
  always @(posedge clk) begin
    dq[0] <= (o_div_divisor == 0) ? 32'hFFFF_FFFF : o_div_dividend / o_div_divisor;
    dr[0] <= (o_div_divisor == 0) ? o_div_dividend : o_div_dividend % o_div_divisor;
    for (int k = 1; k < 8; k++) begin
      dq[k] <= dq[k-1];
      dr[k] <= dr[k-1];
    end
  end
  assign i_div_quotient  = dq[7];
  assign i_div_remainder = dr[7];

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got o_valid=1 result %h tag %0d, required no completion (cycle %0d)",
                 o_result, o_tag, cyc);
      end else begin
        e = sb.pop_front();
        check32("result", o_result, e.res);
        check32("tag", {27'd0, o_tag}, {27'd0, e.tag});
        check32("latency", cyc - e.cyc, 32'd9);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp, input bit keep);
    exp_t e;
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    i_tag   = t;
    e.res = exp;
    e.tag = t;
    e.cyc = cyc;
    if (keep) sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d outstanding ops, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Back-to-back table: tags 0..9, expected results hand-computed
  logic [1:0]  t_op  [10] = '{DIVU, REMU, DIV, REM, REM, DIV, REM, DIV, DIVU, REM};
  logic [31:0] t_rs1 [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB};
  logic [31:0] t_rs2 [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
  logic [31:0] t_exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    int done_cnt;
    repeat (3) step();
    rst = 1'b0;
    step();
    check32("reset_valid",  {31'd0, o_valid}, 32'd0);
    check32("reset_result", o_result, 32'd0);
    check32("reset_tag",    {27'd0, o_tag}, 32'd0);
    check32("reset_count",  {28'd0, o_count}, 32'd0);

    // Single op: latency 9, occupancy 1 while in flight
    issue(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    step();
    idle();
    check32("count_single", {28'd0, o_count}, 32'd1);
    drain();
    check32("count_single_done", {28'd0, o_count}, 32'd0);

    // Back-to-back issue with occupancy tracking
    for (int k = 0; k < 20; k++) begin
      if (k < 10) issue(t_op[k], t_rs1[k], t_rs2[k], 5'(k), t_exp[k], 1'b1);
      else idle();
      exp_cnt  = (k < 10) ? k : 10;
      done_cnt = (k - 8 < 0) ? 0 : ((k - 8 > 10) ? 10 : k - 8);
      check32("count_b2b", {28'd0, o_count}, 32'(exp_cnt - done_cnt));
      step();
    end
    drain();

    // More sign combinations and unsigned edge cases
    issue(REMU, 32'd9,          32'd0,          5'd11, 32'd9,          1'b1); step();
    issue(DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 5'd12, 32'd3,          1'b1); step();
    issue(REM,  32'hFFFF_FFEC, 32'hFFFF_FFFA, 5'd13, 32'hFFFF_FFFE, 1'b1); step();
    issue(DIVU, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'h7FFF_FFFC, 1'b1); step();
    issue(REMU, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'd1,          1'b1); step();
    idle();
    drain();

    // Flush with a same-cycle op: only that op survives
    issue(DIVU, 32'd50, 32'd5, 5'd1, 32'd10, 1'b0); step();
    issue(DIVU, 32'd60, 32'd5, 5'd2, 32'd12, 1'b0); step();
    issue(DIVU, 32'd70, 32'd5, 5'd3, 32'd14, 1'b0); step();
    check32("count_pre_flush", {28'd0, o_count}, 32'd3);
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd20, 32'hFFFF_FFFD, 1'b1);
    i_flush = 1'b1;
    step();
    idle();
    check32("count_post_flush", {28'd0, o_count}, 32'd1);
    drain();

    // Flush while the op is in the last stage suppresses its completion
    issue(DIVU, 32'd81, 32'd9, 5'd21, 32'd9, 1'b0);
    step();
    idle();
    repeat (7) step();
    check32("count_last_stage", {28'd0, o_count}, 32'd1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check32("count_flush_last", {28'd0, o_count}, 32'd0);
    repeat (3) step();

    // Reset mid-flight drops everything, op during reset ignored
    issue(DIVU, 32'd50, 32'd5, 5'd1, 32'd10, 1'b0); step();
    issue(DIVU, 32'd60, 32'd5, 5'd2, 32'd12, 1'b0); step();
    issue(DIVU, 32'd70, 32'd5, 5'd3, 32'd14, 1'b0); step();
    issue(DIVU, 32'd80, 32'd5, 5'd4, 32'd16, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check32("rst_valid",  {31'd0, o_valid}, 32'd0);
    check32("rst_result", o_result, 32'd0);
    check32("rst_tag",    {27'd0, o_tag}, 32'd0);
    check32("rst_count",  {28'd0, o_count}, 32'd0);
    repeat (12) step();
    check32("rst_result_late", o_result, 32'd0);
    check32("rst_count_late",  {28'd0, o_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
